// File: rtl/bus_router_arb_pkg.sv
// Shared types and helpers for the device bus router/arbiter.
package bus_router_pkg;

    localparam int ADDR_W  = 8;
    localparam int PKT_MAX = 256;
    localparam logic [ADDR_W-1:0] BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } state_t;

    // Destination id sits in the top ADDR_W bits of a packet that is sz bits wide.
    function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int sz);
        return ADDR_W'(pkt >> (sz - ADDR_W));
    endfunction

endpackage

// File: rtl/bus_router_arb_rr_arbiter.sv
// Combinational request arbiter: lowest-index priority, or round-robin starting at ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             hi_hit_s;
    logic             hi_found_s;
    logic             lo_found_s;
    logic [IDX_W-1:0] hi_idx_s;
    logic [IDX_W-1:0] lo_idx_s;

    // Scan downwards so the surviving hit is the lowest index at/after ptr (hi) and overall (lo).
    always_comb begin
        hi_hit_s   = 1'b0;
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        grant      = '0;
        idx        = '0;
        for (int j = N - 1; j >= 0; j--) begin
            hi_hit_s   = req[j] && (j >= int'(ptr));
            hi_idx_s   = hi_hit_s ? IDX_W'(j) : hi_idx_s;
            hi_found_s = hi_found_s | hi_hit_s;
            lo_idx_s   = req[j] ? IDX_W'(j) : lo_idx_s;
            lo_found_s = lo_found_s | req[j];
        end
        // Round-robin wraps to the lowest requester when nothing sits at or above ptr.
        idx = (!fixed && hi_found_s) ? hi_idx_s : lo_idx_s;
        for (int j = 0; j < N; j++) begin
            grant[j] = lo_found_s && (int'(idx) == j);
        end
    end

endmodule

// File: rtl/bus_router_arb.sv
// Device bus router: arbitrates pending device FIFOs, pops one packet, and pushes it
// to its destination device or broadcasts it to every device except the source.
module bus_router_arb
    import bus_router_pkg::*;
#(
    parameter int                pckg_sz   = 24,
    parameter int                drvrs     = 16,
    parameter logic [ADDR_W-1:0] BROADCAST = BROADCAST_ID,
    parameter int                CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    input  logic [drvrs-1:0]                full,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    input  logic                            mode,
    output logic                            busy,
    output logic [CNT_W-1:0]                drop_cnt
);

    localparam int IDX_W = $clog2(drvrs);

    state_t             state_r;
    logic [IDX_W-1:0]   g_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [pckg_sz-1:0] pkt_r;

    logic [drvrs-1:0]   gnt_vec_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic [ADDR_W-1:0]  dest_s;
    logic               bcast_s;
    logic               invalid_s;
    logic [drvrs-1:0]   tgt_s;
    logic               tgt_full_s;
    logic [IDX_W-1:0]   g_next_s;

    rr_arbiter #(
        .N     (drvrs),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (pndng),
        .ptr   (rr_ptr_r),
        .fixed (mode),
        .grant (gnt_vec_s),
        .idx   (gnt_idx_s)
    );

    // Decode the held packet: destination, validity, target set and its backpressure.
    always_comb begin
        dest_s     = dest_of(PKT_MAX'(pkt_r), pckg_sz);
        bcast_s    = (dest_s == BROADCAST);
        invalid_s  = (!bcast_s && (int'(dest_s) >= drvrs)) || (int'(dest_s) == int'(g_r));
        tgt_s      = '0;
        for (int j = 0; j < drvrs; j++) begin
            tgt_s[j] = bcast_s ? (j != int'(g_r)) : (int'(dest_s) == j);
        end
        tgt_full_s = |(tgt_s & full);
        g_next_s   = (int'(g_r) == drvrs - 1) ? '0 : g_r + IDX_W'(1'b1);
    end

    // Packet FSM; outputs are registered one state ahead so they line up with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            g_r      <= '0;
            rr_ptr_r <= '0;
            pkt_r    <= '0;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pop  <= '0;
            push <= '0;
            case (state_r)
                IDLE: begin
                    if (|pndng) begin
                        g_r     <= gnt_idx_s;
                        pop     <= gnt_vec_s;
                        busy    <= 1'b1;
                        state_r <= POP;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                POP: begin
                    pkt_r   <= D_pop[g_r];
                    busy    <= 1'b1;
                    state_r <= ROUTE;
                end
                ROUTE: begin
                    if (invalid_s) begin
                        drop_cnt <= (&drop_cnt) ? drop_cnt : drop_cnt + CNT_W'(1'b1);
                        rr_ptr_r <= g_next_s;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else if (tgt_full_s) begin
                        // Broadcast is all-or-nothing: wait until every target has room.
                        busy     <= 1'b1;
                        state_r  <= ROUTE;
                    end else begin
                        push     <= tgt_s;
                        D_push   <= {drvrs{pkt_r}};
                        busy     <= 1'b1;
                        state_r  <= PUSH;
                    end
                end
                PUSH: begin
                    rr_ptr_r <= g_next_s;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_router_arb.sv
// Scoreboard bench for bus_router_arb: device FIFO models feed packets, a monitor
// matches every pop/push against queued expectations.
module tb_bus_router_arb;

    localparam int N  = 4;
    localparam int PW = 24;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][PW-1:0] D_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        full;
    logic [N-1:0]        push;
    logic [N-1:0][PW-1:0] D_push;
    logic                mode;
    logic                busy;
    logic [CW-1:0]       drop_cnt;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [PW-1:0] data;
    } push_exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int push_cyc = 0;
    int push_cnt = 0;
    logic [PW-1:0] devq[N][$];
    logic [N-1:0]  rm;
    logic [N-1:0]  exp_pop[$];
    push_exp_t     exp_push[$];

    bus_router_arb #(
        .pckg_sz   (PW),
        .drvrs     (N),
        .BROADCAST (8'hFF),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .full     (full),
        .push     (push),
        .D_push   (D_push),
        .mode     (mode),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int dev, input logic [PW-1:0] pkt);
        devq[dev].push_back(pkt);
    endtask

    task automatic expect_push(input logic [N-1:0] mask, input logic [PW-1:0] data);
        push_exp_t e;
        e.mask = mask;
        e.data = data;
        exp_push.push_back(e);
    endtask

    function automatic bit idle_all();
        for (int i = 0; i < N; i++) begin
            if (devq[i].size() != 0) return 1'b0;
        end
        return !busy && (rm == '0) && (exp_pop.size() == 0) && (exp_push.size() == 0);
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while (!idle_all() && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_drain_timeout"}, {127'd0, idle_all()}, 128'd1);
    endtask

    task automatic wait_pops(input string tag);
        int n = 0;
        while (exp_pop.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_pop_timeout"}, exp_pop.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_pop"}, pop, 0);
        chk({tag, "_push"}, push, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_d_push"}, D_push, 0);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    // Device FIFO models: first-word-fall-through, head removed the cycle after pop.
    initial begin
        pndng = '0;
        D_pop = '0;
        rm    = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rm[i] && devq[i].size() > 0) void'(devq[i].pop_front());
                rm[i]    = pop[i];
                pndng[i] = (devq[i].size() > 0);
                D_pop[i] = (devq[i].size() > 0) ? devq[i][0] : '0;
            end
        end
    end

    // Monitor: pops/compares expectations whenever the DUT strobes pop or push.
    initial begin
        logic [N-1:0] prev_pop;
        logic [N-1:0] ep;
        push_exp_t    e;
        prev_pop = '0;
        forever begin
            @(negedge clk);
            if (pop != '0) begin
                pop_cyc = cyc;
                chk("pop_onehot", $countones(pop), 1);
                chk("pop_single_cycle", prev_pop, 0);
                chk("pop_push_exclusive", push, 0);
                checks++;
                if (exp_pop.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got %0h, expected no pop", pop);
                end else begin
                    ep = exp_pop.pop_front();
                    if (pop !== ep) begin
                        errors++;
                        $display("FAIL pop_grant: got %0h, expected %0h", pop, ep);
                    end
                end
            end
            if (push != '0) begin
                push_cyc = cyc;
                push_cnt++;
                checks++;
                if (exp_push.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push: got %0h, expected no push", push);
                end else begin
                    e = exp_push.pop_front();
                    chk("push_mask", push, e.mask);
                    chk("push_data", D_push, {N{e.data}});
                end
            end
            prev_pop = pop;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int pc;
        reset = 1'b1;
        full  = '0;
        mode  = 1'b0;
        do_reset("rst0");

        // Single unicast: latency and data.
        c0 = cyc;
        send(1, 24'h02ABCD);
        exp_pop.push_back(4'b0010);
        expect_push(4'b0100, 24'h02ABCD);
        drain("t1");
        chk("t1_pop_latency", pop_cyc - c0, 2);
        chk("t1_push_latency", push_cyc - c0, 4);
        chk("t1_drop_cnt", drop_cnt, 0);

        // Round-robin from pointer 0 with all devices pending.
        do_reset("rst1");
        send(0, 24'h010001); send(0, 24'h020002);
        send(1, 24'h021111); send(2, 24'h032222); send(3, 24'h003333);
        exp_pop.push_back(4'b0001); exp_pop.push_back(4'b0010); exp_pop.push_back(4'b0100);
        exp_pop.push_back(4'b1000); exp_pop.push_back(4'b0001);
        expect_push(4'b0010, 24'h010001);
        expect_push(4'b0100, 24'h021111);
        expect_push(4'b1000, 24'h032222);
        expect_push(4'b0001, 24'h003333);
        expect_push(4'b0100, 24'h020002);
        drain("t2");

        // Fixed priority: device 0 keeps winning while pending (rr pointer is 1 here).
        mode = 1'b1;
        send(0, 24'h01A000); send(0, 24'h01A001); send(0, 24'h01A002);
        send(2, 24'h00B000);
        exp_pop.push_back(4'b0001); exp_pop.push_back(4'b0001);
        exp_pop.push_back(4'b0001); exp_pop.push_back(4'b0100);
        expect_push(4'b0010, 24'h01A000);
        expect_push(4'b0010, 24'h01A001);
        expect_push(4'b0010, 24'h01A002);
        expect_push(4'b0001, 24'h00B000);
        drain("t3");
        mode = 1'b0;

        // Broadcast stalls while any target is full.
        full = 4'b0001;
        send(2, 24'hFF1234);
        exp_pop.push_back(4'b0100);
        expect_push(4'b1011, 24'hFF1234);
        wait_pops("t4");
        pc = push_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("t4_stall_busy", busy, 1);
        chk("t4_stall_no_push", push_cnt, pc);
        full = 4'b0000;
        drain("t4");

        // Undeliverable packets: out of range, to self; counter saturates at 3.
        send(0, 24'h070000); exp_pop.push_back(4'b0001); drain("t5a");
        send(3, 24'h030000); exp_pop.push_back(4'b1000); drain("t5b");
        chk("t5_drop_cnt_2", drop_cnt, 2);
        send(1, 24'h010000); exp_pop.push_back(4'b0010); drain("t5c");
        send(0, 24'h100000); exp_pop.push_back(4'b0001); drain("t5d");
        send(2, 24'h020000); exp_pop.push_back(4'b0100); drain("t5e");
        chk("t5_drop_cnt_sat", drop_cnt, 3);

        // Reset while stalled in ROUTE; afterwards device 0 wins round-robin.
        send(1, 24'h005A5A); exp_pop.push_back(4'b0010); expect_push(4'b0001, 24'h005A5A);
        drain("t6a");
        full = 4'b0010;
        send(2, 24'h015555);
        exp_pop.push_back(4'b0100);
        wait_pops("t6");
        repeat (3) @(negedge clk);
        #1;
        chk("t6_stall_busy", busy, 1);
        do_reset("rst_mid");
        full = 4'b0000;
        send(0, 24'h01C0C0); send(3, 24'h02D0D0);
        exp_pop.push_back(4'b0001); exp_pop.push_back(4'b1000);
        expect_push(4'b0010, 24'h01C0C0);
        expect_push(4'b0100, 24'h02D0D0);
        drain("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_router_arb.md
Name: bus_router_arb

Overview:
- Next-generation bus generator/arbiter for the device bus.
- Each of `drvrs` devices exposes a first-word-fall-through output FIFO: a `pndng` flag plus head data on `D_pop`.
- The block arbitrates among pending devices, pops one packet, and decodes the 8-bit destination header. It then pushes the packet to one device or broadcasts it to all devices except the source.
- New over the previous generation:
  - selectable arbitration mode (round-robin or fixed priority);
  - per-destination backpressure;
  - broadcast;
  - a drop counter for undeliverable packets.

Parameters:
- pckg_sz, 24, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination id, the rest is payload.
- drvrs, 16, number of devices (2..255).
- BROADCAST, 8'hFF, destination id meaning all devices except the source.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pndng  input  drvrs  bit i high when device i's FIFO holds a packet.
- D_pop  input  drvrs x pckg_sz  head packet of device i, stable while pndng[i] is high.
- pop  output  drvrs  one-cycle pulse to dequeue device i's head.
- full  input  drvrs  device i cannot accept a push this cycle.
- push  output  drvrs  one-cycle write strobe into device i.
- D_push  output  drvrs x pckg_sz  packet data, identical on all lanes, qualified by push.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only in IDLE.
- busy  output  1  high whenever state != IDLE.
- drop_cnt  output  CNT_W  count of dropped packets; saturates at all-ones.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high) sets state=IDLE and clears pop, push, D_push, busy, drop_cnt, the round-robin pointer and the held packet.
- Reset during POP/ROUTE/PUSH: a packet already popped is lost; no push follows.

State machine (IDLE, POP, ROUTE, PUSH):
- IDLE:
  - If |pndng, compute winner g: mode=1 gives the lowest set index; mode=0 gives the first set index at or after rr_ptr, wrapping modulo drvrs.
  - Latch g, next state POP.
  - Otherwise stay in IDLE.
- POP:
  - pop[g]=1 for exactly this cycle.
  - At the closing edge, pkt <= D_pop[g]; next state ROUTE.
- ROUTE: let dest = pkt[pckg_sz-1 -: 8].
  - Invalid: dest >= drvrs and dest != BROADCAST, or dest == g. Action: drop_cnt++ (saturating), rr_ptr <= g+1 mod drvrs, next state IDLE.
  - Target set T: {dest} for unicast; all j != g for broadcast.
  - If any full[j] for j in T, stay in ROUTE (stall, unbounded); otherwise next state PUSH.
- PUSH:
  - push[j]=1 for all j in T; D_push lanes = pkt.
  - rr_ptr <= g+1 mod drvrs; next state IDLE.

Timing and ordering:
- Latency from pndng high in IDLE, with no stall: pop in cycle +1, push in cycle +3.
- Minimum 4 cycles per packet; one packet in flight.
- pop and push are never asserted in the same cycle.
- At most one pop bit is set at any time.
- Changes to pndng or mode outside IDLE are ignored.
- full is sampled only in ROUTE; full changing while in PUSH does not cancel the push.
- Broadcast is all-or-nothing: it stalls until every target is not full.
- D_push holds its last value between pushes.

Decomposition:
- Package bus_router_pkg:
  - ADDR_W=8;
  - default BROADCAST;
  - state enum {IDLE, POP, ROUTE, PUSH};
  - function dest_of(pkt).
- Sub-module rr_arbiter (parameter N):
  - inputs req, ptr, fixed;
  - outputs a one-hot grant and its index;
  - purely combinational.

Test Plan:
- drvrs=4, pckg_sz=24. Device 1 presents 24'h02_ABCD with full=0 → pop[1] one cycle; three cycles after pndng is seen, push=4'b0100 with D_push=24'h02ABCD; drop_cnt stays 0.
- Round-robin fairness, mode=0: pndng=4'b1111 held, all packets to valid destinations → grant order 0,1,2,3,0. With mode=1 → grants 0,0,0 while device 0 stays pending.
- Device 2 sends 24'hFF_1234 with full=4'b0001 → stays in ROUTE; after full drops to 0, one push=4'b1011 with D_push=24'hFF1234.
- Invalid destinations: device 0 sends dest 8'h07, then device 3 sends dest 8'h03 (itself) → no push; drop_cnt=2. With CNT_W=2, five drops → drop_cnt holds 3.
- Reset mid-operation: reset asserted in ROUTE → next sample shows pop=0, push=0, busy=0, drop_cnt=0; after release, device 0 is granted first in round-robin mode.
